// File: rtl/mrv1_mtcore_pkg.sv
// Shared types for the multithreaded-core issue stage: per-thread run state,
// per-thread event strobes and the stall-counter width.
package mrv1_mtcore_pkg;

   // Per-thread scheduling state
   typedef enum logic [1:0] {
      TW_OFF = 2'd0,
      TW_RUN = 2'd1,
      TW_BLK = 2'd2
   } tw_state_e;

   // Width of each per-thread BLK-cycle counter
   localparam int unsigned TW_STALL_CNT_W = 16;

   // Pre-decoded events aimed at a single thread slot in one cycle
   typedef struct packed {
      logic start;   // OFF -> RUN request
      logic stop;    // force OFF, overrides everything else
      logic push;    // decode wrote one entry into this thread's buffer
      logic grant;   // scheduler grant, already qualified by ready
      logic blk;     // granted instruction is long-latency
      logic wb;      // long-latency writeback for this thread
   } tw_evt_s;

endpackage : mrv1_mtcore_pkg

// File: rtl/mrv1_tw_rdy_slot.sv
// One thread's run-state FSM and instruction-buffer occupancy counter.
// Optional macro MRV1_TW_RDY_PERF_EN adds a saturating BLK-cycle counter.
module mrv1_tw_rdy_slot
   import mrv1_mtcore_pkg::*;
#(
   parameter int unsigned IBUF_DEPTH_P = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  tw_evt_s                   evt_i,
   output logic                      rdy_o,
   output logic                      full_o,
   output logic                      active_o
`ifdef MRV1_TW_RDY_PERF_EN
   ,
   output logic [TW_STALL_CNT_W-1:0] stall_cnt_o
`endif
);

   localparam int unsigned occ_width_lp = $clog2(IBUF_DEPTH_P + 1);
   localparam logic [occ_width_lp-1:0] occ_full_lp = occ_width_lp'(IBUF_DEPTH_P);

   tw_state_e               state_q;
   tw_state_e               state_n;
   logic [occ_width_lp-1:0] occ_q;
   logic [occ_width_lp-1:0] occ_n;
   logic                    push_ok;
   logic                    pop_ok;

   // Next state and occupancy; stop overrides start, grant and writeback
   always_comb begin
      state_n = state_q;
      occ_n   = occ_q;
      push_ok = evt_i.push && (state_q != TW_OFF) && (occ_q != occ_full_lp);
      pop_ok  = evt_i.grant && (state_q == TW_RUN) && (occ_q != '0);

      if (evt_i.stop) begin
         state_n = TW_OFF;
         occ_n   = '0;
      end else begin
         case (state_q)
            TW_OFF:  if (evt_i.start)         state_n = TW_RUN;
            TW_RUN:  if (pop_ok && evt_i.blk) state_n = TW_BLK;
            TW_BLK:  if (evt_i.wb)            state_n = TW_RUN;
            default:                          state_n = TW_OFF;
         endcase

         case ({push_ok, pop_ok})
            2'b10:   occ_n = occ_q + occ_width_lp'(1);
            2'b01:   occ_n = occ_q - occ_width_lp'(1);
            default: occ_n = occ_q;
         endcase
      end
   end

   // State register; outputs are registered from the next-state values
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= TW_OFF;
         occ_q    <= '0;
         rdy_o    <= 1'b0;
         full_o   <= 1'b0;
         active_o <= 1'b0;
      end else begin
         state_q  <= state_n;
         occ_q    <= occ_n;
         rdy_o    <= (state_n == TW_RUN) && (occ_n != '0);
         full_o   <= (occ_n == occ_full_lp);
         active_o <= (state_n != TW_OFF);
      end
   end

`ifdef MRV1_TW_RDY_PERF_EN
   logic [TW_STALL_CNT_W-1:0] stall_cnt_q;

   // Counts cycles spent in BLK; restarts from zero on each OFF->RUN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_cnt_q <= '0;
      end else if ((state_q == TW_OFF) && (state_n == TW_RUN)) begin
         stall_cnt_q <= '0;
      end else if ((state_q == TW_BLK) && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + TW_STALL_CNT_W'(1);
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule : mrv1_tw_rdy_slot

// File: rtl/mrv1_issue_tw_rdy_tracker.sv
// Issue-stage thread-ready tracker: decodes thread ids into per-slot
// strobes, collects the per-thread ready/full/active bits and flags grants
// to threads that were not ready.
// Optional macro MRV1_TW_RDY_PERF_EN adds per-thread BLK-cycle counters.
module mrv1_issue_tw_rdy_tracker
   import mrv1_mtcore_pkg::*;
#(
   parameter  int unsigned NUM_TW_P      = 8,
   parameter  int unsigned IBUF_DEPTH_P  = 4,
   localparam int unsigned twid_width_lp = (NUM_TW_P > 1) ? $clog2(NUM_TW_P) : 1
) (
   input  logic                                     clk_i,
   input  logic                                     rst_ni,
   input  logic [NUM_TW_P-1:0]                      tw_start_i,
   input  logic [NUM_TW_P-1:0]                      tw_stop_i,
   input  logic                                     dec_vld_i,
   input  logic [twid_width_lp-1:0]                 dec_twid_i,
   output logic [NUM_TW_P-1:0]                      ibuf_full_o,
   input  logic                                     issue_vld_i,
   input  logic [twid_width_lp-1:0]                 issue_twid_i,
   input  logic                                     issue_blk_i,
   input  logic                                     wb_vld_i,
   input  logic [twid_width_lp-1:0]                 wb_twid_i,
   output logic [NUM_TW_P-1:0]                      issue_rdy_o,
   output logic [NUM_TW_P-1:0]                      tw_active_o,
   output logic                                     grant_err_o
`ifdef MRV1_TW_RDY_PERF_EN
   ,
   output logic [NUM_TW_P-1:0][TW_STALL_CNT_W-1:0]  stall_cnt_o
`endif
);

   tw_evt_s [NUM_TW_P-1:0] evt;
   logic    [NUM_TW_P-1:0] dec_sel;
   logic    [NUM_TW_P-1:0] iss_sel;
   logic    [NUM_TW_P-1:0] wb_sel;
   logic                   grant_hit;
   logic                   grant_bad;

   // One-hot thread-id decode; ids beyond the thread count select nothing
   always_comb begin
      dec_sel = '0;
      iss_sel = '0;
      wb_sel  = '0;
      for (int i = 0; i < NUM_TW_P; i++) begin
         dec_sel[i] = (32'(dec_twid_i)   < NUM_TW_P) && (dec_twid_i   == twid_width_lp'(i));
         iss_sel[i] = (32'(issue_twid_i) < NUM_TW_P) && (issue_twid_i == twid_width_lp'(i));
         wb_sel[i]  = (32'(wb_twid_i)    < NUM_TW_P) && (wb_twid_i    == twid_width_lp'(i));
      end
   end

   // A grant is good only if it lands on a thread currently showing ready
   always_comb begin
      grant_hit = |(iss_sel & issue_rdy_o);
      grant_bad = issue_vld_i && !grant_hit;
   end

   // Per-slot event strobes; bad grants are withheld so they change nothing
   always_comb begin
      evt = '0;
      for (int i = 0; i < NUM_TW_P; i++) begin
         evt[i].start = tw_start_i[i];
         evt[i].stop  = tw_stop_i[i];
         evt[i].push  = dec_vld_i && dec_sel[i];
         evt[i].grant = issue_vld_i && iss_sel[i] && issue_rdy_o[i];
         evt[i].blk   = issue_blk_i;
         evt[i].wb    = wb_vld_i && wb_sel[i];
      end
   end

   // Sticky grant-error flag, cleared only by reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         grant_err_o <= 1'b0;
      end else if (grant_bad) begin
         grant_err_o <= 1'b1;
      end
   end

   for (genvar g = 0; g < NUM_TW_P; g++) begin : g_slot
      mrv1_tw_rdy_slot #(
         .IBUF_DEPTH_P (IBUF_DEPTH_P)
      ) u_slot (
         .clk_i       (clk_i),
         .rst_ni      (rst_ni),
         .evt_i       (evt[g]),
         .rdy_o       (issue_rdy_o[g]),
         .full_o      (ibuf_full_o[g]),
         .active_o    (tw_active_o[g])
`ifdef MRV1_TW_RDY_PERF_EN
         ,
         .stall_cnt_o (stall_cnt_o[g])
`endif
      );
   end

endmodule : mrv1_issue_tw_rdy_tracker

// File: doc/mrv1_issue_tw_rdy_tracker.md
Name: mrv1_issue_tw_rdy_tracker

Overview:
- Producer side of the issue-stage thread-selection interface: tracks per-thread state and generates the issue_rdy vector that the issue scheduler arbitrates over.
- Consumes the scheduler's grant (valid + twid) and retires credits.
- Sits between decode/instruction-buffer bookkeeping and the issue thread scheduler.
- Holds per-thread buffer occupancy, long-latency blocking and run state; stores no instruction payload.

Parameters:
- NUM_TW_P, 8, number of hardware threads (warps).
- IBUF_DEPTH_P, 4, per-thread instruction-buffer entries; power of two, >= 2.
- twid_width_lp, $clog2(NUM_TW_P), thread-id width (local, derived).
- occ_width_lp, $clog2(IBUF_DEPTH_P+1), occupancy counter width (local, derived).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous assert, active-low.
- tw_start_i  in  NUM_TW_P  per-thread start pulse.
- tw_stop_i  in  NUM_TW_P  per-thread stop pulse.
- dec_vld_i  in  1  decoded instruction written to the buffer of dec_twid_i.
- dec_twid_i  in  twid_width_lp  thread of the decode push.
- ibuf_full_o  out  NUM_TW_P  thread buffer full; decode must not push that thread.
- issue_vld_i  in  1  scheduler grant valid.
- issue_twid_i  in  twid_width_lp  granted thread.
- issue_blk_i  in  1  granted instruction is long-latency (load/div); blocks its thread until writeback.
- wb_vld_i  in  1  long-latency writeback completes.
- wb_twid_i  in  twid_width_lp  thread of the writeback.
- issue_rdy_o  out  NUM_TW_P  thread eligible for issue this cycle.
- tw_active_o  out  NUM_TW_P  thread not in OFF.
- grant_err_o  out  1  sticky: grant received for a thread not ready.

Behaviour:
- Reset, asynchronous on rst_ni low:
  - All threads OFF, occupancy 0, blocked 0, grant_err_o 0.
  - Outputs: issue_rdy_o = 0, tw_active_o = 0, ibuf_full_o = 0.
- Per-thread FSM states: OFF, RUN, BLK.
  - OFF -> RUN on tw_start_i[i].
  - RUN -> BLK on a valid grant to i with issue_blk_i = 1.
  - BLK -> RUN on wb_vld_i with wb_twid_i = i.
  - RUN or BLK -> OFF on tw_stop_i[i]. Stop wins over start, grant and writeback in the same cycle.
  - Entering OFF clears occupancy.
  - Start while not OFF: ignored.
  - Writeback to a thread not in BLK: ignored.
- Occupancy counter (occ_width_lp bits):
  - +1 on decode push; -1 on valid grant; push and grant to the same thread in one cycle leaves it unchanged.
  - Saturates at IBUF_DEPTH_P; a push while full is dropped.
  - Never underflows; a grant at occupancy 0 is an error and leaves the counter unchanged.
  - Decode push to an OFF thread: dropped.
- issue_rdy_o[i] = (state RUN) & (occ != 0). Combinational from registered state only; no input-to-output path.
- ibuf_full_o[i] = (occ == IBUF_DEPTH_P); registered-state based.
- Grant turnaround: a grant updates state at the clock edge, so the new ready value appears the cycle after the grant (1-cycle latency).
  - A thread with occ = 1 granted in cycle t deasserts ready in t+1 unless it was pushed in t.
- Writeback completes in cycle t: thread returns to RUN; ready in t+1 if occ != 0.
- Grant with issue_blk_i = 1 and same-cycle writeback to the same thread: the thread ends in BLK (grant wins).
- grant_err_o sets when issue_vld_i is high and issue_rdy_o[issue_twid_i] is low in the same cycle.
  - The bad grant causes no state change.
  - Cleared only by reset.
- issue_twid_i / dec_twid_i / wb_twid_i >= NUM_TW_P: the event is ignored; a grant with such an id sets grant_err_o.

Optional Feature:
- Macro: MRV1_TW_RDY_PERF_EN.
- Defined:
  - Adds output stall_cnt_o, NUM_TW_P x 16 bits: per-thread counter of cycles spent in BLK.
  - Each counter saturates at 16'hFFFF and is cleared on reset or on an OFF->RUN transition.
- Undefined: no port and no counter logic; all other behaviour identical.

Decomposition:
- Package mrv1_mtcore_pkg holds:
  - enum tw_state_e {TW_OFF, TW_RUN, TW_BLK}, 2 bits.
  - Constant TW_STALL_CNT_W = 16.
- One natural sub-module, mrv1_tw_rdy_slot, instantiated NUM_TW_P times in a generate loop.
  - Holds one thread's FSM and occupancy counter.
  - Takes pre-decoded per-thread push/grant/wb/start/stop strobes.
- Top level does the twid decode, the OR-reduction for error detection, and output concatenation.

Test Plan:
- Reset, then start thread 3 and push 2 entries to thread 3 -> issue_rdy_o = 8'h08 from the cycle after the 1st push; grants in t and t+1 -> ready low at t+2; occupancy 0.
- Push 4 entries to thread 0 -> ibuf_full_o[0] = 1; a 5th push is dropped; one grant -> ibuf_full_o[0] = 0 next cycle, occupancy 3.
- Thread 5 with occupancy 2, grant with issue_blk_i = 1 -> issue_rdy_o[5] = 0 while BLK; wb to thread 5 -> ready = 1 the following cycle.
- Same-cycle push and grant on thread 1 at occupancy 1 -> occupancy stays 1, ready stays 1; same-cycle stop and grant on thread 1 -> OFF, occupancy 0, tw_active_o[1] = 0.
- Grant to thread 2 while it is OFF -> grant_err_o = 1 next cycle and stays 1; no state change; drop rst_ni mid-sequence -> all outputs 0 immediately, without waiting for a clock edge.
- With MRV1_TW_RDY_PERF_EN: hold thread 4 in BLK for 10 cycles -> stall_cnt_o[4] = 10; stop then start thread 4 -> 0.
